// File: rtl/aes_pkg.sv
// Shared FSM type, round-counter width and fixed AES-128 decryption round keys.
// The keys are the team key schedule, expanded from cipher key 000102..0e0f.
package aes_pkg;

   localparam int ROUND_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } fsm_t;

   localparam logic [127:0] KEY0  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] KEY2  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
   localparam logic [127:0] KEY3  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
   localparam logic [127:0] KEY4  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
   localparam logic [127:0] KEY5  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
   localparam logic [127:0] KEY6  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
   localparam logic [127:0] KEY7  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
   localparam logic [127:0] KEY8  = 128'h47438735a41c65b9e016baf4aebf7ad2;
   localparam logic [127:0] KEY9  = 128'h549932d1f08557681093ed9cbe2c974e;
   localparam logic [127:0] KEY10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   function automatic logic [127:0] round_key(input logic [ROUND_W-1:0] idx);
      logic [127:0] k;
      case (idx)
         4'd0:    k = KEY0;
         4'd1:    k = KEY1;
         4'd2:    k = KEY2;
         4'd3:    k = KEY3;
         4'd4:    k = KEY4;
         4'd5:    k = KEY5;
         4'd6:    k = KEY6;
         4'd7:    k = KEY7;
         4'd8:    k = KEY8;
         4'd9:    k = KEY9;
         default: k = KEY10;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// last_round skips InvMixColumns; zero latency, no flow control.
module aes_inv_round (
   input  logic [127:0] state_in,
   input  logic [127:0] rkey,
   input  logic         last_round,
   output logic [127:0] state_out
);

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240;
      x2   = gmul(x, x);
      x3   = gmul(x2, x);
      x12  = gmul(gmul(x3, x3), gmul(x3, x3));
      x15  = gmul(x12, x3);
      x240 = gmul(x15, x15);
      x240 = gmul(x240, x240);
      x240 = gmul(x240, x240);
      x240 = gmul(x240, x240);
      return gmul(gmul(x240, x12), x2);
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
   endfunction

   logic [7:0] ak [16];

   // Byte n of the block is row n%4, column n/4; row r rotates right by r.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            ak[r+4*c] = inv_sbox(state_in[127-8*(r+4*((c-r+4)%4)) -: 8])
                        ^ rkey[127-8*(r+4*c) -: 8];
         end
      end
   end

   always_comb begin
      state_out = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (last_round) begin
               state_out[127-8*(r+4*c) -: 8] = ak[r+4*c];
            end else begin
               state_out[127-8*(r+4*c) -: 8] = gmul(ak[4*c+r],         8'h0e)
                                             ^ gmul(ak[4*c+(r+1)%4], 8'h0b)
                                             ^ gmul(ak[4*c+(r+2)%4], 8'h0d)
                                             ^ gmul(ak[4*c+(r+3)%4], 8'h09);
            end
         end
      end
   end

endmodule

// File: rtl/aes_dec_seq.sv
// Iterative AES-128 decryptor: one inverse round per cycle, out_valid 10 edges after accept, one block per 11 cycles.
// Output holds until out_ready; input stalls while busy. Define AES_DEC_ABORT_EN to add the abort port.
module aes_dec_seq
   import aes_pkg::*;
#(
   parameter int NROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy,
   output logic [3:0]   round
`ifdef AES_DEC_ABORT_EN
   ,
   input  logic         abort
`endif
);

   fsm_t               fsm_q, fsm_nx;
   logic [127:0]       state_q, state_nx;
   logic [127:0]       data_nx;
   logic               valid_nx;
   logic [ROUND_W-1:0] round_nx;
   logic [127:0]       round_out;
   logic               accept;
   logic               abort_i;

`ifdef AES_DEC_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   // Gated by rst_n so nothing is offered while reset is held, yet the first edge after release can accept.
   assign in_ready = rst_n & ~abort_i & ((fsm_q == IDLE) | ((fsm_q == DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   assign busy     = (fsm_q != IDLE);

   aes_inv_round u_round (
      .state_in   (state_q),
      .rkey       (round_key(round)),
      .last_round (fsm_q == FINAL),
      .state_out  (round_out)
   );

   always_comb begin
      fsm_nx   = fsm_q;
      state_nx = state_q;
      round_nx = round;
      data_nx  = out_data;
      valid_nx = out_valid;
      case (fsm_q)
         IDLE: ;
         ROUND: begin
            if (abort_i) begin
               fsm_nx   = IDLE;
               round_nx = '0;
            end else begin
               state_nx = round_out;
               if (round == ROUND_W'(1)) begin
                  fsm_nx   = FINAL;
                  round_nx = '0;
               end else begin
                  round_nx = round - ROUND_W'(1);
               end
            end
         end
         FINAL: begin
            if (abort_i) begin
               fsm_nx   = IDLE;
               round_nx = '0;
            end else begin
               data_nx  = round_out;
               valid_nx = 1'b1;
               fsm_nx   = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               valid_nx = 1'b0;
               fsm_nx   = IDLE;
            end
         end
      endcase
      // Accept last: in DONE it overrides the return to IDLE for zero-bubble streaming.
      if (accept) begin
         state_nx = in_data ^ round_key(ROUND_W'(NROUNDS));
         round_nx = ROUND_W'(NROUNDS - 1);
         fsm_nx   = ROUND;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q     <= IDLE;
         state_q   <= '0;
         round     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         fsm_q     <= fsm_nx;
         state_q   <= state_nx;
         round     <= round_nx;
         out_data  <= data_nx;
         out_valid <= valid_nx;
      end
   end

endmodule

// File: tb/tb_aes_dec_seq.sv
// Self-checking bench for aes_dec_seq: transaction-level reference model plus directed vectors.
module tb_aes_dec_seq;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;
   logic         busy;
   logic [3:0]   round;
   logic         abort = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_dec_seq #(.NROUNDS(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .round     (round)
`ifdef AES_DEC_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- software AES-128 inverse cipher ----------------
   logic [7:0]   sbox  [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk    [11];

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      while (y != 8'h00) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   task automatic build_tables();
      logic [7:0]   inv, b, s, rc;
      logic [31:0]  w [44];
      logic [31:0]  t;
      logic [127:0] ck;
      for (int i = 0; i < 256; i++) begin
         inv = 8'h00;
         for (int j = 1; j < 256; j++) if (gm(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
         b = inv;
         s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
         sbox[i]  = s;
         isbox[s] = 8'(i);
      end
      ck = 128'h000102030405060708090a0b0c0d0e0f;
      for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] aes_dec(input logic [127:0] ct);
      logic [7:0]   st [4][4];
      logic [7:0]   col [4];
      logic [7:0]   m [4][4];
      logic [7:0]   tmp;
      logic [127:0] res;
      m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
            '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            st[r][c] = ct[127-8*(r+4*c) -: 8] ^ rk[10][127-8*(r+4*c) -: 8];
      for (int n = 9; n >= 0; n--) begin
         for (int r = 1; r < 4; r++) begin
            for (int k = 0; k < r; k++) begin
               tmp = st[r][3]; st[r][3] = st[r][2]; st[r][2] = st[r][1];
               st[r][1] = st[r][0]; st[r][0] = tmp;
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               st[r][c] = isbox[st[r][c]] ^ rk[n][127-8*(r+4*c) -: 8];
         if (n != 0) begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) col[r] = st[r][c];
               for (int r = 0; r < 4; r++) begin
                  tmp = 8'h00;
                  for (int k = 0; k < 4; k++) tmp = tmp ^ gm(m[r][k], col[k]);
                  st[r][c] = tmp;
               end
            end
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(r+4*c) -: 8] = st[r][c];
      return res;
   endfunction

   // ---------------- transaction model ----------------
   // m_pend: a block is in flight, m_cnt edges after its accept; m_val: result waiting.
   logic         m_pend = 1'b0;
   logic         m_val  = 1'b0;
   int           m_cnt  = 0;
   logic [127:0] m_blk  = '0;
   logic [127:0] m_data = '0;
   logic         exp_rdy, m_acc;

   assign exp_rdy = rst_n & ~abort & ~m_pend & (~m_val | out_ready);
   assign m_acc   = in_valid & exp_rdy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend <= 1'b0;
         m_val  <= 1'b0;
         m_cnt  <= 0;
         m_data <= '0;
      end else begin
         if (m_val && out_ready) m_val <= 1'b0;
         if (m_pend) begin
            if (abort) begin
               m_pend <= 1'b0;
            end else if (m_cnt == 9) begin
               m_pend <= 1'b0;
               m_val  <= 1'b1;
               m_data <= m_blk;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
         if (m_acc) begin
            m_pend <= 1'b1;
            m_cnt  <= 0;
            m_blk  <= aes_dec(in_data);
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_out_valid", out_valid, m_val);
      check("cmp_busy", busy, m_pend | m_val);
      check("cmp_round", round, m_pend ? 9 - m_cnt : 0);
      check("cmp_in_ready", in_ready, exp_rdy);
      check("cmp_out_data", out_data, m_data);
   end

   // ---------------- back-to-back collector ----------------
   int           cyc = 0;
   int           last_cyc = 0;
   int           got = 0;
   logic         b2b = 1'b0;
   logic [127:0] gold_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (b2b && out_valid && out_ready) begin
         if (gold_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b2b_extra_output: got %h expected none", out_data);
         end else begin
            check("b2b_order", out_data, gold_q.pop_front());
         end
         if (got > 0) check("b2b_interval", cyc - last_cyc, 11);
         last_cyc = cyc;
         got++;
      end
   end

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_valid_timeout"}, out_valid, 1'b1);
   endtask

   task automatic wait_round(input logic [3:0] r, input string name);
      int n;
      n = 0;
      while (round !== r && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_round_reached"}, round, r);
   endtask

   logic [127:0] gold, blk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      build_tables();
      check("pin_sbox_53", sbox[8'h53], 8'hed);
      check("pin_isbox_00", isbox[8'h00], 8'h52);
      check("pin_key10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      check("pin_model_fips", aes_dec(128'h69c4e0d86a7b0430d8cdb78070b4c55a),
            128'h00112233445566778899aabbccddeeff);

      // Reset held: inputs toggle, outputs stay zero.
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         in_valid  = ~in_valid;
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         out_ready = ~out_ready;
      end
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_round", round, 0);
      check("rst_out_data", out_data, 128'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rst_release_in_ready", in_ready, 1);

      // Single block of zeros with the consumer stalled.
      out_ready = 1'b0;
      in_data   = '0;
      in_valid  = 1'b1;
      gold      = aes_dec(128'h0);
      @(posedge clk); #1;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      check("single_round_first", round, 9);
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         check("single_round_seq", round, 9 - k);
         check("single_no_early_valid", out_valid, 0);
         in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      check("single_latency10", out_valid, 1);
      check("single_data", out_data, gold);

      // Backpressure: result held, input ignored.
      for (int k = 0; k < 5; k++) begin
         in_data = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         check("bp_valid_held", out_valid, 1);
         check("bp_data_held", out_data, gold);
         check("bp_in_ready_low", in_ready, 0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(posedge clk); #1;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_idle", busy, 0);
      check("bp_data_retained", out_data, gold);

      // Known-answer vector.
      in_data  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid("fips");
      check("fips_plaintext", out_data, 128'h00112233445566778899aabbccddeeff);
      @(posedge clk); #1;

      // Back-to-back stream with in_valid and out_ready high.
      b2b = 1'b1;
      for (int i = 0; i < 20; i++) begin
         int n;
         blk = {$urandom, $urandom, $urandom, $urandom};
         gold_q.push_back(aes_dec(blk));
         in_valid = 1'b1;
         in_data  = blk;
         n = 0;
         @(negedge clk);
         while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("b2b_accept_timeout", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 30 && got < 20; k++) begin
         @(posedge clk); #1;
      end
      check("b2b_count", got, 20);
      b2b = 1'b0;

      // Reset in the middle of a block.
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_round(4'd5, "midrst");
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_round", round, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_out_data", out_data, 128'h0);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_data  = '1;
      gold     = aes_dec('1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("midrst_first_accept", busy, 1);
      wait_valid("ones");
      check("ones_plaintext", out_data, gold);
      @(posedge clk); #1;

`ifdef AES_DEC_ABORT_EN
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_round(4'd3, "abort");
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_idle", busy, 0);
      check("abort_round", round, 0);
      check("abort_no_valid", out_valid, 0);
      check("abort_data_kept", out_data, gold);
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
      end
      check("abort_never_valid", out_valid, 0);
      in_valid = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      check("abort_blocks_ready", in_ready, 0);
      @(posedge clk); #1;
      check("abort_blocks_accept", busy, 0);
      in_valid = 1'b0;
      abort    = 1'b0;
      @(posedge clk); #1;
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
